// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the pwm block.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH_DEFAULT = 8;

    // Period length (and one past the max count) for a given counter width.
    function automatic int unsigned pwm_period(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    typedef logic [PWM_WIDTH_DEFAULT-1:0] pwm_duty_t;

endpackage

// File: rtl/pwm_counter.sv
// Period counter: counts 0..PERIOD-1, then wraps. Flags the last clock of each period.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clkin,
    input  logic             reset,
    output logic [WIDTH-1:0] cnt,
    output logic             last_c
);

    localparam int unsigned      PERIOD   = pwm_period(WIDTH);
    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        last_c = (cnt_q == LAST_CNT);
        cnt_d  = cnt_q + WIDTH'(1);
        if (last_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm.sv
// Fixed-frequency PWM: out is registered high while cnt < effective duty.
// Define PWM_SHADOW_EN to latch duty_cycle only on the last clock of each period.
module pwm
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [WIDTH-1:0] duty_cycle,
    output logic             out
);

    logic [WIDTH-1:0] cnt;
    logic             last_c;
    logic [WIDTH-1:0] duty_eff_c;
    logic             out_d;
    logic             out_q;

    pwm_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clkin  (clkin),
        .reset  (reset),
        .cnt    (cnt),
        .last_c (last_c)
    );

`ifdef PWM_SHADOW_EN
    // Shadow duty only changes at the period boundary, so pulses are never truncated.
    logic [WIDTH-1:0] duty_d;
    logic [WIDTH-1:0] duty_q;

    always_comb begin
        duty_d = duty_q;
        if (last_c) begin
            duty_d = duty_cycle;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_eff_c = duty_q;
`else
    logic unused_last;

    assign unused_last = last_c;
    assign duty_eff_c  = duty_cycle;
`endif

    always_comb begin
        out_d = (cnt < duty_eff_c);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm; follows PWM_SHADOW_EN when it is defined for the build.
module tb_pwm;
    import pwm_pkg::*;

    localparam int unsigned W = PWM_WIDTH_DEFAULT;
    localparam int          P = 255;
`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic      clkin = 1'b0;
    logic      reset = 1'b1;
    pwm_duty_t duty_cycle = '0;
    logic      out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: position within the period and the latched duty (shadow build).
    int m_phase  = 0;
    int m_shadow = 0;

    pwm #(
        .WIDTH (W)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .duty_cycle (duty_cycle),
        .out        (out)
    );

    always #5 clkin = ~clkin;

    // Apply inputs for one clock, advance the model, return expected out after the edge.
    task automatic step(input bit rst, input int duty, output bit exp_o);
        int eff;
        @(negedge clkin);
        reset      = rst;
        duty_cycle = W'(duty);
        if (rst) begin
            m_phase  = 0;
            m_shadow = 0;
            exp_o    = 1'b0;
        end else begin
            eff   = SHADOW ? m_shadow : duty;
            exp_o = (m_phase < eff);
            if (SHADOW && m_phase == P - 1) m_shadow = duty;
            m_phase = (m_phase + 1) % P;
        end
        @(posedge clkin);
        #1;
    endtask

    task automatic test_reset();
        bit e;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 64, e);
            n_cmp++;
            if (out !== 1'b0) begin
                n_err++;
                $display("FAIL reset_out: cycle %0d out=%b expected=0", i, out);
            end
            n_cmp++;
            if (dut.cnt !== '0) begin
                n_err++;
                $display("FAIL reset_cnt: cycle %0d cnt=%0d expected=0", i, dut.cnt);
            end
        end
        step(1'b0, 64, e);
        n_cmp++;
        if (out !== e) begin
            n_err++;
            $display("FAIL reset_release: out=%b expected=%b", out, e);
        end
    endtask

    task automatic test_level(input int duty);
        bit e;
        int highs;
        int lows;
        int exp_cnt;
        highs = 0;
        lows  = 0;
        step(1'b1, duty, e);
        for (int i = 0; i < 600; i++) begin
            step(1'b0, duty, e);
            n_cmp++;
            if (out !== e) begin
                n_err++;
                $display("FAIL level_%0d: cycle %0d out=%b expected=%b", duty, i, out, e);
            end
            if (out === 1'b1) highs++;
            else lows++;
        end
        n_cmp++;
        if (duty == 0) begin
            if (highs != 0) begin
                n_err++;
                $display("FAIL level_0_highs: got=%0d expected=0", highs);
            end
        end else begin
            exp_cnt = SHADOW ? P : 0;
            if (lows != exp_cnt) begin
                n_err++;
                $display("FAIL level_full_lows: got=%0d expected=%0d", lows, exp_cnt);
            end
        end
    endtask

    task automatic test_steady(input int duty);
        bit   e;
        logic prev;
        int   run_len;
        int   last_rise;
        bit   started;
        int   exp_len;
        step(1'b1, duty, e);
        prev      = out;
        run_len   = 0;
        last_rise = -1;
        started   = 1'b0;
        for (int i = 0; i < 4 * P; i++) begin
            step(1'b0, duty, e);
            n_cmp++;
            if (out !== e) begin
                n_err++;
                $display("FAIL steady_%0d: cycle %0d out=%b expected=%b", duty, i, out, e);
            end
            if (out !== prev) begin
                if (started) begin
                    exp_len = (prev === 1'b1) ? duty : P - duty;
                    n_cmp++;
                    if (run_len != exp_len) begin
                        n_err++;
                        $display("FAIL steady_%0d_run: level=%b len=%0d expected=%0d",
                                 duty, prev, run_len, exp_len);
                    end
                end
                if (out === 1'b1) begin
                    if (last_rise >= 0) begin
                        n_cmp++;
                        if (i - last_rise != P) begin
                            n_err++;
                            $display("FAIL steady_%0d_spacing: got=%0d expected=%0d",
                                     duty, i - last_rise, P);
                        end
                    end
                    last_rise = i;
                end
                started = 1'b1;
                run_len = 1;
            end else begin
                run_len++;
            end
            prev = out;
        end
    endtask

    task automatic test_change();
        bit e;
        int hi_a;
        int hi_b;
        int d;
        hi_a = 0;
        hi_b = 0;
        step(1'b1, 64, e);
        for (int ph = 0; ph < P; ph++) begin
            step(1'b0, 64, e);
            n_cmp++;
            if (out !== e) begin
                n_err++;
                $display("FAIL change_warm: phase %0d out=%b expected=%b", ph, out, e);
            end
        end
        for (int ph = 0; ph < 2 * P; ph++) begin
            d = (ph >= 100) ? 192 : 64;
            step(1'b0, d, e);
            n_cmp++;
            if (out !== e) begin
                n_err++;
                $display("FAIL change_cycle: step %0d out=%b expected=%b", ph, out, e);
            end
            if (out === 1'b1) begin
                if (ph < P) hi_a++;
                else hi_b++;
            end
        end
        n_cmp++;
        if (hi_a != (SHADOW ? 64 : 156)) begin
            n_err++;
            $display("FAIL change_period_a: highs=%0d expected=%0d", hi_a, SHADOW ? 64 : 156);
        end
        n_cmp++;
        if (hi_b != 192) begin
            n_err++;
            $display("FAIL change_period_b: highs=%0d expected=192", hi_b);
        end
    endtask

    task automatic test_reset_mid();
        bit e;
        int highs;
        highs = 0;
        step(1'b1, 64, e);
        for (int i = 0; i < 30; i++) step(1'b0, 64, e);
        step(1'b1, 64, e);
        n_cmp++;
        if (out !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_out: out=%b expected=0", out);
        end
        n_cmp++;
        if (dut.cnt !== '0) begin
            n_err++;
            $display("FAIL mid_reset_cnt: cnt=%0d expected=0", dut.cnt);
        end
        for (int i = 0; i < 2 * P; i++) begin
            step(1'b0, 64, e);
            n_cmp++;
            if (out !== e) begin
                n_err++;
                $display("FAIL mid_reset_cycle: cycle %0d out=%b expected=%b", i, out, e);
            end
            if (out === 1'b1) highs++;
        end
        n_cmp++;
        if (highs != (SHADOW ? 64 : 128)) begin
            n_err++;
            $display("FAIL mid_reset_highs: got=%0d expected=%0d", highs, SHADOW ? 64 : 128);
        end
    endtask

    task automatic test_random();
        bit e;
        bit rst;
        int duty;
        duty = 100;
        step(1'b1, duty, e);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0:       duty = 0;
                    1:       duty = 255;
                    2:       duty = 128;
                    default: duty = int'($urandom_range(0, 255));
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            step(rst, duty, e);
            n_cmp++;
            if (out !== e) begin
                n_err++;
                $display("FAIL random: cycle %0d duty=%0d out=%b expected=%b", i, duty, out, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_level(0);
        test_level(255);
        test_steady(64);
        test_steady(128);
        test_steady(192);
        test_change();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
